// File: rtl/maincontrol_mc.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback from the opcode.
// Optional feature: define MC_ADDI_EN to decode addi (001000) through ADDIEX/ADDIWB.
module maincontrol_mc (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] pcsource,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = S_FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    alusrca     = 1'b0;
    pcsource    = 2'b00;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
        state_d = memready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        state_d = memready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        state_d  = memready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_RTWB;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    // A reset cycle must never commit anything, whatever state it interrupts.
    if (rst) begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      memwrite    = 1'b0;
      regwrite    = 1'b0;
      irwrite     = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_maincontrol_mc.sv
// Scoreboard bench for maincontrol_mc: each driven cycle pushes its expected state/outputs, popped at negedge.
module tb_maincontrol_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       memready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg;
  logic       irwrite, regwrite, regdst, alusrca, illegal;
  logic [1:0] pcsource, alusrcb, aluop;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;

`ifdef MC_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [3:0] expState;
    logic [16:0] expOut;
  } expect_t;

  expect_t sb[$];

  maincontrol_mc dut (
    .clk(clk), .rst(rst), .op(op), .memready(memready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .alusrca(alusrca), .pcsource(pcsource), .alusrcb(alusrcb),
    .aluop(aluop), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  // Reference output table, indexed by the state the cycle is expected to be in.
  function automatic logic [16:0] expOutputs(input logic [3:0] s, input logic mr,
                                             input logic [5:0] o, input logic r);
    logic pw, pwc, io, mrd, mw, mtr, irw, rw, rd, asa, ill;
    logic [1:0] ps, asb, aop;
    {pw, pwc, io, mrd, mw, mtr, irw, rw, rd, asa, ill} = '0;
    ps = 2'b00; asb = 2'b00; aop = 2'b00;
    case (s)
      4'd0: begin mrd = 1; asb = 2'b01; irw = mr; pw = mr; end
      4'd1: begin
        asb = 2'b11;
        ill = !(o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
                o == 6'b000100 || o == 6'b000010 || (ADDI_EN && o == 6'b001000));
      end
      4'd2: begin asa = 1; asb = 2'b10; end
      4'd3: begin mrd = 1; io = 1; end
      4'd4: begin rw = 1; mtr = 1; end
      4'd5: begin mw = 1; io = 1; end
      4'd6: begin asa = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9: begin pw = 1; ps = 2'b10; end
      4'd10: if (ADDI_EN) begin asa = 1; asb = 2'b10; end
      4'd11: if (ADDI_EN) rw = 1;
      default: ;
    endcase
    if (r) {pw, pwc, mw, rw, irw, ill} = '0;
    return {pw, pwc, io, mrd, mw, mtr, irw, rw, rd, asa, ps, asb, aop, ill};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, record what that cycle must show, compare at negedge.
  task automatic applyStimulus(input string tag, input logic r, input logic mr,
                               input logic [5:0] o, input logic [3:0] expState);
    expect_t e;
    expect_t got;
    rst = r; memready = mr; op = o;
    e.tag = tag;
    e.expState = expState;
    e.expOut = expOutputs(expState, mr, o, r);
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      checkOutput({got.tag, "_state"}, 32'(state), 32'(got.expState));
      checkOutput({got.tag, "_outs"},
                  32'({pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                       regwrite, regdst, alusrca, pcsource, alusrcb, aluop, illegal}),
                  32'(got.expOut));
    end
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

  initial begin
    rst = 1'b1; memready = 1'b1; op = R;
    @(posedge clk); #1;
    applyStimulus("rst_hold", 1, 1, R, 4'd0);

    applyStimulus("r_fetch", 0, 1, R, 4'd0);
    applyStimulus("r_decode", 0, 1, R, 4'd1);
    applyStimulus("r_exec", 0, 1, LW, 4'd6);
    applyStimulus("r_rtwb", 0, 1, R, 4'd7);

    applyStimulus("lw_fetch_wait", 0, 0, LW, 4'd0);
    applyStimulus("lw_fetch", 0, 1, LW, 4'd0);
    applyStimulus("lw_decode", 0, 1, LW, 4'd1);
    applyStimulus("lw_memadr", 0, 1, LW, 4'd2);
    applyStimulus("lw_memrd0", 0, 0, SW, 4'd3);
    applyStimulus("lw_memrd1", 0, 0, LW, 4'd3);
    applyStimulus("lw_memrd2", 0, 1, LW, 4'd3);
    applyStimulus("lw_memwb", 0, 1, LW, 4'd4);

    applyStimulus("beq_fetch", 0, 1, BEQ, 4'd0);
    applyStimulus("beq_decode", 0, 1, BEQ, 4'd1);
    applyStimulus("beq_branch", 0, 1, J, 4'd8);

    applyStimulus("j_fetch", 0, 1, J, 4'd0);
    applyStimulus("j_decode", 0, 1, J, 4'd1);
    applyStimulus("j_jump", 0, 1, J, 4'd9);

    applyStimulus("sw_fetch", 0, 1, SW, 4'd0);
    applyStimulus("sw_decode", 0, 1, SW, 4'd1);
    applyStimulus("sw_memadr", 0, 1, SW, 4'd2);
    applyStimulus("sw_memwr0", 0, 0, SW, 4'd5);
    applyStimulus("sw_memwr1", 0, 1, SW, 4'd5);

    applyStimulus("bad_fetch", 0, 1, BAD, 4'd0);
    applyStimulus("bad_decode", 0, 1, BAD, 4'd1);

    applyStimulus("addi_fetch", 0, 1, ADDI, 4'd0);
    applyStimulus("addi_decode", 0, 1, ADDI, 4'd1);
    if (ADDI_EN) begin
      applyStimulus("addi_ex", 0, 1, ADDI, 4'd10);
      applyStimulus("addi_wb", 0, 1, ADDI, 4'd11);
    end

    applyStimulus("swrst_fetch", 0, 1, SW, 4'd0);
    applyStimulus("swrst_decode", 0, 1, SW, 4'd1);
    applyStimulus("swrst_memadr", 0, 1, SW, 4'd2);
    applyStimulus("swrst_memwr", 1, 0, SW, 4'd5);
    applyStimulus("swrst_after", 0, 0, SW, 4'd0);

    applyStimulus("lwrst_fetch", 0, 1, LW, 4'd0);
    applyStimulus("lwrst_decode", 0, 1, LW, 4'd1);
    applyStimulus("lwrst_memadr", 0, 1, LW, 4'd2);
    applyStimulus("lwrst_memrd", 1, 0, LW, 4'd3);
    applyStimulus("lwrst_after", 0, 1, LW, 4'd0);
    applyStimulus("final_decode", 0, 1, R, 4'd1);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/maincontrol_mc.md
# maincontrol_mc

Multicycle MIPS main control unit: a Moore-style state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps from the 6-bit opcode. It produces the datapath enables, the mux selects and the 2-bit `aluop` consumed by the ALU control decoder. It sits between the instruction register and the datapath. It waits on a memory-ready handshake during every memory access.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 6: opcode field `IR[31:26]`, held stable by the instruction register after FETCH.
- `memready` in 1: memory handshake; high means the current read or write completes this cycle.
- `pcwrite`, `pcwritecond`, `iord`, `memread`, `memwrite`, `memtoreg`, `irwrite`, `regwrite`, `regdst`, `alusrca` out 1 each: datapath controls.
- `pcsource` out 2: PC mux select (00 ALU, 01 ALUOut, 10 jump target).
- `alusrcb` out 2: ALU B mux select (00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2).
- `aluop` out 2: encoded as 00 add, 01 subtract, 10 decode funct.
- `illegal` out 1: one-cycle pulse in DECODE when the opcode is unsupported.
- `state` out 4: current state, for debug.

## Operation
Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000 (addi only when configured). Every output not listed for a state is 0.
- 0 FETCH
  - Outputs: memread=1, alusrcb=01, aluop=00; irwrite=pcwrite=memready.
  - Next: memready ? DECODE : FETCH.
- 1 DECODE
  - Outputs: alusrcb=11, aluop=00.
  - Next: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX.
  - Any other opcode: →FETCH with illegal=1.
- 2 MEMADR
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: lw→MEMRD, sw→MEMWR.
- 3 MEMRD
  - Outputs: memread=1, iord=1.
  - Next: memready ? MEMWB : MEMRD.
- 4 MEMWB
  - Outputs: regwrite=1, memtoreg=1, regdst=0.
  - Next: →FETCH.
- 5 MEMWR
  - Outputs: memwrite=1, iord=1.
  - Next: memready ? FETCH : MEMWR.
- 6 EXEC
  - Outputs: alusrca=1, alusrcb=00, aluop=10.
  - Next: →RTWB.
- 7 RTWB
  - Outputs: regwrite=1, regdst=1, memtoreg=0.
  - Next: →FETCH.
- 8 BRANCH
  - Outputs: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01.
  - Next: →FETCH.
- 9 JUMP
  - Outputs: pcwrite=1, pcsource=10.
  - Next: →FETCH.
- 10 ADDIEX
  - Outputs: alusrca=1, alusrcb=10, aluop=00.
  - Next: →ADDIWB.
- 11 ADDIWB
  - Outputs: regwrite=1, regdst=0, memtoreg=0.
  - Next: →FETCH.
- Encodings 12–15: all outputs 0; →FETCH next edge.

## Timing
- Outputs are combinational from `state`. Exceptions: `irwrite` and `pcwrite` in FETCH, and `illegal`, also depend on `memready` or `op` in the same cycle.
- Cycle counts with memready tied high: R 4, lw 5, sw 4, beq 3, j 3, addi 4.
- Each cycle memready is low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset values:
  - On the edge with rst=1, state←FETCH. The next cycle shows FETCH outputs: memread=1, alusrcb=01, all else 0 except irwrite/pcwrite=memready.
  - While rst=1, irwrite, pcwrite, pcwritecond, memwrite, regwrite and illegal are forced 0 regardless of state.
- Reset mid-instruction, including mid memory wait, abandons the instruction with no further write enables.
- `op` is sampled in DECODE and MEMADR only. Changes to `op` in other states have no effect.

## Configuration
- `MC_ADDI_EN` defined:
  - addi (001000) is decoded in DECODE to ADDIEX→ADDIWB.
- `MC_ADDI_EN` undefined:
  - 001000 is illegal: DECODE asserts illegal=1 and returns to FETCH.
  - States 10/11 are unreachable and treated as unused encodings.

## Test plan
- Reset held 2 cycles, then released with memready=1 → state=0; memread=1, irwrite=1, pcwrite=1, alusrcb=01 in the first post-reset cycle.
- R-type (op=000000), memready=1 → states 0,1,6,7,0; aluop=10 in state 6; regwrite=1 and regdst=1 only in state 7.
- lw (100011) with memready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; iord=1 for 3 cycles; memtoreg=1 in state 4.
- beq (000100) → states 0,1,8,0; in state 8: aluop=01, pcwritecond=1, pcsource=01, pcwrite=0.
- op=111111 → illegal=1 for one cycle in DECODE, then FETCH; same for 001000 when `MC_ADDI_EN` is undefined. With the macro defined, 001000 → states 0,1,10,11,0.
- sw (101011) with rst asserted during MEMWR → memwrite=0 that cycle; state=0 on the next cycle.
